// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, branch/jump redirect, stall hold,
// and halt once the PC runs past the end of the instruction ROM.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_ADDR = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic        if_valid_q, if_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] branch_target_s;
    logic [31:0] jump_target_s;
    logic [31:0] redirect_target_s;
    logic        redirect_s;

    // Both targets are relative to the instruction now sitting in IF/ID.
    assign branch_target_s   = if_pc_plus4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign jump_target_s     = {if_pc_plus4_q[31:28], jump_index, 2'b00};
    assign redirect_s        = jump | branch_taken;
    assign redirect_target_s = jump ? jump_target_s : branch_target_s;

    // Next-state logic for the PC, the IF/ID register and the run/halt FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            RUN: begin
                halted_d = 1'b0;
                if (redirect_s) begin
                    pc_d       = redirect_target_s;
                    if_instr_d = 32'h0000_0000;
                    if_valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pc_q < HALT_ADDR) begin
                    if_instr_d    = imem_data;
                    if_pc_plus4_d = pc_q + 32'd4;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end else begin
                    if_instr_d = 32'h0000_0000;
                    if_valid_d = 1'b0;
                    state_d    = HALT;
                    halted_d   = 1'b1;
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
                halted_d   = 1'b1;
            end
            default: begin
                state_d  = RUN;
                halted_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_instr_q    <= 32'h0000_0000;
            if_pc_plus4_q <= 32'h0000_0000;
            if_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_valid    = if_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall, redirects, halt, reset.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int total_cnt = 0;
    int pass_cnt  = 0;

    instr_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .if_instr     (if_instr),
        .if_pc_plus4  (if_pc_plus4),
        .if_valid     (if_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    // ROM word is a fixed tag OR'ed with its byte address, so captures are traceable.
    assign imem_data = 32'hA500_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0000;
        jump = 1'b0; jump_index = 26'h0;
        step(); step();
        reset = 1'b0;
        check("rst_pc", imem_addr, 32'h0000_0000);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_instr", if_instr, 32'h0000_0000);
        check("rst_pc4", if_pc_plus4, 32'h0000_0000);

        // Sequential fetch
        step();
        check("seq1_pc", imem_addr, 32'h0000_0004);
        check("seq1_pc4", if_pc_plus4, 32'h0000_0004);
        check("seq1_instr", if_instr, 32'hA500_0000);
        step();
        check("seq2_pc", imem_addr, 32'h0000_0008);
        check("seq2_pc4", if_pc_plus4, 32'h0000_0008);
        step();
        check("seq3_pc", imem_addr, 32'h0000_000C);
        check("seq3_pc4", if_pc_plus4, 32'h0000_000C);
        check("seq3_instr", if_instr, 32'hA500_0008);
        check("seq3_count", fetch_count, 32'd3);
        check("seq3_valid", {31'd0, if_valid}, 32'd1);

        // Stall holds everything for two cycles
        stall = 1'b1;
        step(); step();
        check("stall_pc", imem_addr, 32'h0000_000C);
        check("stall_instr", if_instr, 32'hA500_0008);
        check("stall_count", fetch_count, 32'd3);
        check("stall_valid", {31'd0, if_valid}, 32'd1);

        // Jump overrides stall: target {0, 0xD, 00} = 0x34
        jump = 1'b1; jump_index = 26'h00_000D;
        step();
        jump = 1'b0; stall = 1'b0;
        check("jstall_pc", imem_addr, 32'h0000_0034);
        check("jstall_valid", {31'd0, if_valid}, 32'd0);
        check("jstall_instr", if_instr, 32'h0000_0000);
        check("jstall_count", fetch_count, 32'd3);
        step();
        check("cap34_pc4", if_pc_plus4, 32'h0000_0038);
        check("cap34_instr", if_instr, 32'hA500_0034);
        check("cap34_count", fetch_count, 32'd4);

        // Forward branch: 0x38 + 2*4 = 0x40
        branch_taken = 1'b1; branch_offset = 16'h0002;
        step();
        branch_taken = 1'b0;
        check("brf_pc", imem_addr, 32'h0000_0040);
        check("brf_valid", {31'd0, if_valid}, 32'd0);
        check("brf_count", fetch_count, 32'd4);
        step();
        check("brf_cap_pc4", if_pc_plus4, 32'h0000_0044);
        check("brf_cap_valid", {31'd0, if_valid}, 32'd1);
        check("brf_cap_count", fetch_count, 32'd5);

        // Backward branch: 0x44 - 2*4 = 0x3C
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        check("brb_pc", imem_addr, 32'h0000_003C);
        step();
        check("brb_cap_pc4", if_pc_plus4, 32'h0000_0040);
        check("brb_cap_count", fetch_count, 32'd6);

        // Jump wins over branch: jump 0x4C vs branch 0x48
        jump = 1'b1; jump_index = 26'h00_0013; branch_taken = 1'b1; branch_offset = 16'h0002;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        check("jprio_pc", imem_addr, 32'h0000_004C);
        check("jprio_valid", {31'd0, if_valid}, 32'd0);

        // Reset mid-run while stalled at pc 0x20
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();
        check("run8_pc", imem_addr, 32'h0000_0020);
        check("run8_count", fetch_count, 32'd8);
        stall = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; stall = 1'b0;
        check("rstmid_pc", imem_addr, 32'h0000_0000);
        check("rstmid_valid", {31'd0, if_valid}, 32'd0);
        check("rstmid_count", fetch_count, 32'd0);

        // Run to the end of the ROM
        repeat (256) step();
        check("end_pc", imem_addr, 32'h0000_0400);
        check("end_count", fetch_count, 32'd256);
        check("end_instr", if_instr, 32'hA500_03FC);
        check("end_halted", {31'd0, halted}, 32'd0);
        step();
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, if_valid}, 32'd0);
        check("halt_pc", imem_addr, 32'h0000_0400);
        check("halt_count", fetch_count, 32'd256);
        check("halt_pc4", if_pc_plus4, 32'h0000_0400);

        // Redirects are ignored while halted
        jump = 1'b1; jump_index = 26'h00_0004;
        step();
        jump = 1'b0;
        check("hjmp_pc", imem_addr, 32'h0000_0400);
        check("hjmp_halted", {31'd0, halted}, 32'd1);
        check("hjmp_count", fetch_count, 32'd256);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("hrst_pc", imem_addr, 32'h0000_0000);
        check("hrst_halted", {31'd0, halted}, 32'd0);
        step();
        check("hrst_run_pc", imem_addr, 32'h0000_0004);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
